mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Request sequencer sitting directly upstream of the 4-bank × 1024 × 8 memory macro. It accepts read/write requests over a valid/ready handshake, buffers them in a small FIFO, and drives the macro's cen/rd/wr/add/din/rst pins with the required hold times. It captures read data after a fixed latency and returns it on a response handshake. It also sequences whole-array clear operations through the macro's reset pin.

## Interface
- DEPTH, 4, request FIFO entries (power of two, ≥2)
- RD_LAT, 3, cycles mem_rd is held before mem_dout is sampled (≥2)
- WR_CYC, 2, cycles mem_wr/add/din are held for a write (≥1)
- CLR_CYC, 2, cycles mem_rst is held for a clear (≥1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  12  [11:10] bank, [9:0] word
- req_wdata  in  8  write data
- clear_req  in  1  one-cycle pulse: clear entire array
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts read data
- rsp_data  out  8  read data
- rsp_addr  out  12  address of returned read
- busy  out  1  FSM not in IDLE, or FIFO non-empty, or clear pending
- mem_cen  out  1  chip enable, active-low
- mem_rd, mem_wr, mem_rst  out  1  macro controls
- mem_add  out  12  macro address
- mem_din  out  8  macro write data
- mem_dout  in  8  macro read data

## Operation
- Push on req_valid && req_ready. There is no bypass: a pushed request is popped no earlier than the next cycle.
- clear_req sets a sticky clr_pend flag. The flag is cleared on entry to CLR. Pulses that arrive while pending merge.
- FSM states and transitions:
  - IDLE:
    - clr_pend → CLR. Clear has priority over the FIFO.
    - Otherwise, FIFO non-empty → pop the head, register its addr/data, then go to WR or RD.
  - WR: mem_cen=0, mem_wr=1, mem_add/mem_din from the popped entry, held WR_CYC cycles → GAP.
  - RD: mem_cen=0, mem_rd=1, mem_add held RD_LAT cycles. mem_dout is sampled into rsp_data at the rising edge ending the last RD cycle → RSP.
  - RSP: rsp_valid=1, with rsp_data/rsp_addr stable. On rsp_ready → GAP.
  - CLR: mem_cen=1, mem_rst=1 for CLR_CYC cycles → GAP.
  - GAP: one cycle with mem_cen=1 and rd=wr=rst=0 → IDLE.
- mem_add/mem_din hold their last value outside WR/RD.
- rd, wr and rst are never high together.
- Outside WR/RD, mem_cen=1.
- Bank is taken only from the address. There is no wrap or increment logic.
- Requests queued behind a clear are executed after it. A read after a clear returns 8'h00.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - mem_cen=1
  - mem_rd=mem_wr=mem_rst=0
  - mem_add=0, mem_din=0
  - rsp_valid=0, rsp_data=0, rsp_addr=0
  - req_ready=0, busy=0
  - FIFO empty, clr_pend=0, state IDLE
- Asserting reset mid-operation aborts the operation. It flushes the FIFO and drops any pending clear. No partial response is produced.
- First cycle after rst_n rises: req_ready=1.
- Write latency, counted from the accept edge:
  - 1 cycle in the FIFO, then 1 cycle IDLE pop.
  - mem_wr high for WR_CYC cycles.
  - 1 GAP cycle.
  - Back-to-back writes therefore issue every WR_CYC+2 cycles.
- Read: rsp_valid rises RD_LAT+2 cycles after the accept edge, given an empty FIFO and idle FSM. It stays high, with data stable, until sampled with rsp_ready.
- Full FIFO: req_ready=0. A pop in cycle N raises req_ready in cycle N+1.
- clear_req during RD/WR/RSP: the current operation completes, then CLR runs. The FIFO contents are kept.
- clear_req while already in CLR: the flag re-latches, so a second clear runs afterwards.

## Structure
- Package mem_ctrl_pkg:
  - ADDR_W=12, DATA_W=8, BANK_W=2
  - state enum {IDLE, WR, RD, RSP, CLR, GAP}
  - request struct {wr, addr, wdata}
- Sub-module mem_req_fifo: DEPTH-entry synchronous FIFO of the request struct, with full/empty flags and asynchronous active-low reset.
- The top level contains the FSM, the hold counter (width ≥ clog2 of max(RD_LAT, WR_CYC, CLR_CYC)+1), clr_pend and the response registers.

## Test plan
- Reset values: hold rst_n low with random inputs → all outputs at their reset values and req_ready=0; release rst_n → req_ready=1 next cycle.
- Write then read:
  - Write 8'hA5 to 12'h7FF → mem_wr high for exactly 2 cycles with mem_add=12'h7FF, mem_din=8'hA5.
  - Read 12'h7FF → rsp_valid after 5 cycles, rsp_data=8'hA5, rsp_addr=12'h7FF.
- Backpressure on both sides:
  - Push 6 writes with the FSM stalled → req_ready drops after 4 accepts.
  - Hold rsp_ready=0 on a read for 10 cycles → rsp_valid and rsp_data stay stable, with no further mem_rd.
- Clear during a read: pulse clear_req mid-RD on 12'h400 (holding 8'h3C), with a read of 12'h400 queued:
  - The first response returns 8'h3C.
  - mem_rst is then high for 2 cycles with mem_cen=1.
  - The second response returns 8'h00.
- Asynchronous reset mid-write: drop rst_n during WR → mem_wr=0 and mem_cen=1 immediately, FIFO empty, no response.
- Protocol invariants over a 1000-request random run: rd/wr/rst are never high together; mem_cen=1 in every GAP cycle; responses arrive in request order.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, FSM states and request record for the memory request sequencer
package mem_ctrl_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int BANK_W = 2;
    localparam int WORD_W = ADDR_W - BANK_W;

    typedef enum logic [2:0] {IDLE, WR, RD, RSP, CLR, GAP} state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;
endpackage

// File: rtl/mem_req_ctrl_if.sv
// rtl/mem_req_ctrl_if.sv - request, response and macro pin bundle of the memory request sequencer
interface mem_req_ctrl_if;
    import mem_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              clear_req;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              busy;
    logic              mem_cen;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_rst;
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, clear_req, rsp_ready, mem_dout,
        output req_ready, rsp_valid, rsp_data, rsp_addr, busy,
               mem_cen, mem_rd, mem_wr, mem_rst, mem_add, mem_din
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, clear_req, rsp_ready, mem_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, busy,
               mem_cen, mem_rd, mem_wr, mem_rst, mem_add, mem_din
    );
endinterface

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - DEPTH-entry synchronous request FIFO with full/empty flags
module mem_req_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  req_t din,
    input  logic pop,
    output req_t dout,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(DEPTH);

    req_t             store [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) store[wr_ptr[PTR_W-1:0]] <= din;
    end

    assign dout  = store[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - sequences queued read/write/clear requests onto the 4-bank memory macro pins
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int RD_LAT  = 3,
    parameter int WR_CYC  = 2,
    parameter int CLR_CYC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_req_ctrl_if.master bus
);
    localparam int MAX_A   = (RD_LAT > WR_CYC) ? RD_LAT : WR_CYC;
    localparam int MAX_CYC = (MAX_A > CLR_CYC) ? MAX_A : CLR_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              run_q;
    logic              head_seen;
    logic              clr_pend;
    logic              clr_take;
    logic              pop;
    logic              push;
    logic              full;
    logic              empty;
    req_t              in_req;
    req_t              head;
    logic [ADDR_W-1:0] add_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ADDR_W-1:0] rsp_addr_q;

    assign push   = bus.req_valid && bus.req_ready;
    assign in_req = '{wr: bus.req_wr, addr: bus.req_addr, wdata: bus.req_wdata};

    mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (in_req),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        clr_take = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_pend) begin
                    state_n  = CLR;
                    clr_take = 1'b1;
                end else if (head_seen && !empty) begin
                    pop     = 1'b1;
                    state_n = head.wr ? WR : RD;
                end
            end
            WR:      if (cnt == CNT_W'(WR_CYC - 1))  state_n = GAP;
            RD:      if (cnt == CNT_W'(RD_LAT - 1))  state_n = RSP;
            RSP:     if (bus.rsp_ready)              state_n = GAP;
            CLR:     if (cnt == CNT_W'(CLR_CYC - 1)) state_n = GAP;
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The hold counter restarts on every state change; it is only compared in WR/RD/CLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            run_q     <= 1'b0;
            head_seen <= 1'b0;
            clr_pend  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= (state_n != state) ? '0 : cnt + 1'b1;
            run_q     <= 1'b1;
            head_seen <= !empty;
            if (bus.clear_req)  clr_pend <= 1'b1;
            else if (clr_take)  clr_pend <= 1'b0;
        end
    end

    // A newly written entry becomes visible to IDLE one cycle after the FIFO reports it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_q      <= '0;
            din_q      <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
        end else begin
            if (pop) begin
                add_q <= head.addr;
                din_q <= head.wdata;
            end
            if (state == RD && state_n == RSP) begin
                rsp_data_q <= bus.mem_dout;
                rsp_addr_q <= add_q;
            end
        end
    end

    assign bus.req_ready = run_q && !full;
    assign bus.rsp_valid = (state == RSP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.busy      = (state != IDLE) || !empty || clr_pend;
    assign bus.mem_cen   = !((state == WR) || (state == RD));
    assign bus.mem_wr    = (state == WR);
    assign bus.mem_rd    = (state == RD);
    assign bus.mem_rst   = (state == CLR);
    assign bus.mem_add   = add_q;
    assign bus.mem_din   = din_q;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - self-checking bench for mem_req_ctrl with a behavioural macro and request-order model
module tb_mem_req_ctrl;
    import mem_ctrl_pkg::*;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_req_ctrl_if bus();

    mem_req_ctrl #(.DEPTH(4), .RD_LAT(3), .WR_CYC(2), .CLR_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural macro: synchronous write, registered read, reset clears the whole array.
    logic [7:0] macro [4096] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.mem_rst) begin
            for (int i = 0; i < 4096; i++) macro[i] <= 8'h00;
        end else if (!bus.mem_cen && bus.mem_wr) begin
            macro[bus.mem_add] <= bus.mem_din;
        end
        if (!bus.mem_cen && bus.mem_rd) bus.mem_dout <= macro[bus.mem_add];
    end

    int         n_chk;
    int         n_fail;
    bit         mon_en;
    rsp_t       exp_q[$];
    logic [7:0] model [4096] = '{default: 8'h00};
    vec_t       vecs [9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic posd();
        @(posedge clk);
        #1;
    endtask

    task automatic negs();
        @(negedge clk);
        check("ctl_exclusive", 64'($countones({bus.mem_rd, bus.mem_wr, bus.mem_rst}) <= 1), 64'(1));
        check("cen_outside_access", 64'(bus.mem_cen), 64'(!(bus.mem_rd || bus.mem_wr)));
        if (mon_en && bus.rsp_valid && bus.rsp_ready) begin
            check("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_addr_order", 64'(bus.rsp_addr), 64'(e.addr));
                check("rsp_data_model", 64'(bus.rsp_data), 64'(e.data));
            end
        end
    endtask

    task automatic do_op(input vec_t t);
        int          first_hit = -1;
        int          wr_cnt = 0;
        logic [7:0]  dat = 8'h00;
        logic [11:0] ad = 12'h000;
        posd();
        bus.req_valid = 1'b1;
        bus.req_wr    = t.wr;
        bus.req_addr  = t.addr;
        bus.req_wdata = t.wdata;
        bus.rsp_ready = 1'b1;
        negs();
        check("op_req_ready", 64'(bus.req_ready), 64'(1));
        posd();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            negs();
            if (t.wr && bus.mem_wr) begin
                wr_cnt++;
                if (first_hit < 0) first_hit = k;
                check("wr_mem_add", 64'(bus.mem_add), 64'(t.addr));
                check("wr_mem_din", 64'(bus.mem_din), 64'(t.wdata));
            end
            if (!t.wr && bus.rsp_valid && first_hit < 0) begin
                first_hit = k;
                dat = bus.rsp_data;
                ad  = bus.rsp_addr;
            end
        end
        if (t.wr) begin
            check("wr_cycles", 64'(wr_cnt), 64'(2));
            check("wr_start", 64'(first_hit), 64'(2));
        end else begin
            check("rd_latency", 64'(first_hit), 64'(5));
            check("rd_data", 64'(dat), 64'(t.exp));
            check("rd_addr", 64'(ad), 64'(t.addr));
        end
    endtask

    task automatic drain_and_clear();
        for (int g = 0; g < 300 && (bus.busy || exp_q.size() != 0); g++) begin
            bus.rsp_ready = 1'b1;
            negs();
            posd();
        end
        check("drain_idle", 64'(bus.busy), 64'(0));
        check("drain_queue", 64'(exp_q.size()), 64'(0));
        bus.clear_req = 1'b1;
        negs();
        posd();
        bus.clear_req = 1'b0;
        for (int g = 0; g < 20 && bus.busy; g++) begin
            negs();
            posd();
        end
        check("clear_done", 64'(bus.busy), 64'(0));
        for (int i = 0; i < 4096; i++) model[i] = 8'h00;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         acc;
    int         rd_seen;
    int         n_rsp;
    int         rst_cyc;
    int         cen_bad;
    int         order_bad;
    int         hits;
    logic       prev_ready;
    logic       seen_wr;
    logic       accepted;
    logic [7:0] got [2];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mon_en = 1'b0;
        vecs[0] = '{1'b1, 12'h7FF, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 12'h7FF, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 12'h000, 8'h11, 8'h00};
        vecs[3] = '{1'b1, 12'hC00, 8'h22, 8'h00};
        vecs[4] = '{1'b0, 12'h000, 8'h00, 8'h11};
        vecs[5] = '{1'b0, 12'hC00, 8'h00, 8'h22};
        vecs[6] = '{1'b1, 12'h400, 8'h3C, 8'h00};
        vecs[7] = '{1'b0, 12'h400, 8'h00, 8'h3C};
        vecs[8] = '{1'b0, 12'h3FF, 8'h00, 8'h00};

        // Reset with random inputs
        for (int i = 0; i < 6; i++) begin
            posd();
            bus.req_valid = 1'($urandom);
            bus.req_wr    = 1'($urandom);
            bus.req_addr  = 12'($urandom);
            bus.req_wdata = 8'($urandom);
            bus.clear_req = 1'($urandom);
            bus.rsp_ready = 1'($urandom);
            negs();
            check("reset_ctl", 64'({bus.mem_cen, bus.mem_rd, bus.mem_wr, bus.mem_rst,
                                    bus.rsp_valid, bus.req_ready, bus.busy}), 64'(7'b1000000));
            check("reset_data", 64'({bus.mem_add, bus.mem_din, bus.rsp_data, bus.rsp_addr}), 64'(0));
        end
        posd();
        bus.req_valid = 1'b0;
        bus.clear_req = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b1;
        posd();
        negs();
        check("ready_after_reset", 64'(bus.req_ready), 64'(1));

        for (int v = 0; v < 9; v++) do_op(vecs[v]);

        // Response backpressure with the FIFO filling behind it
        posd();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 12'h7FF;
        posd();
        bus.req_valid = 1'b0;
        for (int g = 0; g < 20 && !bus.rsp_valid; g++) negs();
        check("bp_rsp_seen", 64'(bus.rsp_valid), 64'(1));
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            posd();
            bus.req_valid = 1'b1;
            bus.req_wr    = 1'b1;
            bus.req_addr  = 12'(16 + i);
            bus.req_wdata = 8'(80 + i);
            negs();
            if (bus.req_ready) acc++;
        end
        posd();
        bus.req_valid = 1'b0;
        negs();
        check("bp_accepts", 64'(acc), 64'(4));
        check("bp_full_ready", 64'(bus.req_ready), 64'(0));
        rd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            negs();
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
            check("bp_rsp_data", 64'(bus.rsp_data), 64'(8'hA5));
            if (bus.mem_rd) rd_seen++;
        end
        check("bp_no_rd", 64'(rd_seen), 64'(0));
        posd();
        bus.rsp_ready = 1'b1;
        prev_ready = 1'b0;
        seen_wr = 1'b0;
        for (int g = 0; g < 20 && !seen_wr; g++) begin
            negs();
            if (bus.mem_wr) begin
                seen_wr = 1'b1;
                check("pop_raises_ready", 64'({prev_ready, bus.req_ready}), 64'(2'b01));
                check("bp_first_write", 64'({bus.mem_add, bus.mem_din}), 64'({12'h010, 8'h50}));
            end
            prev_ready = bus.req_ready;
        end
        check("bp_write_issued", 64'(seen_wr), 64'(1));
        for (int g = 0; g < 60 && bus.busy; g++) negs();
        check("bp_drained", 64'(bus.busy), 64'(0));

        // Clear pulsed mid-read with a second read of the same word queued
        posd();
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 12'h400;
        posd();
        posd();
        bus.req_valid = 1'b0;
        for (int g = 0; g < 20 && !bus.mem_rd; g++) negs();
        check("clr_rd_seen", 64'(bus.mem_rd), 64'(1));
        posd();
        bus.clear_req = 1'b1;
        posd();
        bus.clear_req = 1'b0;
        n_rsp = 0; rst_cyc = 0; cen_bad = 0; order_bad = 0;
        got[0] = 8'hFF; got[1] = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            negs();
            if (bus.mem_rst) begin
                rst_cyc++;
                if (!bus.mem_cen) cen_bad++;
                if (n_rsp != 1) order_bad++;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (n_rsp < 2) got[n_rsp] = bus.rsp_data;
                n_rsp++;
            end
        end
        check("clr_rsp_count", 64'(n_rsp), 64'(2));
        check("clr_first_data", 64'(got[0]), 64'(8'h3C));
        check("clr_second_data", 64'(got[1]), 64'(8'h00));
        check("clr_rst_cycles", 64'(rst_cyc), 64'(2));
        check("clr_rst_cen", 64'(cen_bad), 64'(0));
        check("clr_between_rsps", 64'(order_bad), 64'(0));

        // Asynchronous reset in the middle of a write with a read queued
        posd();
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 12'h555;
        bus.req_wdata = 8'h99;
        posd();
        bus.req_wr = 1'b0;
        posd();
        bus.req_valid = 1'b0;
        for (int g = 0; g < 20 && !bus.mem_wr; g++) negs();
        check("ar_wr_seen", 64'(bus.mem_wr), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_abort", 64'({bus.mem_wr, bus.mem_cen, bus.busy, bus.req_ready}), 64'(4'b0100));
        posd();
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            negs();
            if (bus.rsp_valid || bus.mem_rd || bus.mem_wr) hits++;
        end
        check("ar_no_activity", 64'(hits), 64'(0));
        check("ar_idle", 64'(bus.busy), 64'(0));

        posd();
        drain_and_clear();

        // Random traffic checked against an in-order array model
        mon_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            bus.req_valid = 1'b1;
            bus.req_wr    = 1'($urandom);
            bus.req_addr  = {2'($urandom), WORD_W'($urandom_range(0, 15))};
            bus.req_wdata = 8'($urandom);
            accepted = 1'b0;
            for (int g = 0; g < 100 && !accepted; g++) begin
                negs();
                if (bus.req_ready) begin
                    accepted = 1'b1;
                    if (bus.req_wr) model[bus.req_addr] = bus.req_wdata;
                    else exp_q.push_back('{bus.req_addr, model[bus.req_addr]});
                end
                posd();
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
            bus.req_valid = 1'b0;
            if (!accepted) check("rnd_accept", 64'(accepted), 64'(1));
            repeat ($urandom_range(0, 2)) begin
                negs();
                posd();
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (n % 250 == 249) drain_and_clear();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
